// File: rtl/uart_echo_responder.sv
// rtl/uart_echo_responder.sv - far-end UART model: receive, check, buffer and echo bytes XOR-ed with a mask
module uart_echo_responder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baud_div,
  input  logic        par_en,
  input  logic        par_odd,
  input  logic        rx_en,
  input  logic        tx_en,
  input  logic [7:0]  xor_mask,
  input  logic        rx,
  output logic        tx,
  output logic        busy,
  output logic [15:0] rx_cnt,
  output logic [7:0]  err_cnt,
  output logic [7:0]  state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} fsm_t;

  fsm_t        rx_st, tx_st;
  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] rx_div, rx_ctr, tx_div, tx_ctr;
  logic [2:0]  rx_bit, tx_bit;
  logic [7:0]  rx_sh, tx_sh;
  logic        rx_pen, rx_podd, rx_pbad;
  logic        tx_pen, tx_pbit;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] fifo_cnt;
  logic        overrun, par_err, frm_err;

  logic rx_tc, tx_tc, rx_done, rx_good, fifo_full, fifo_empty, pop, push;
  logic [7:0] head;

  assign rx_tc      = (rx_ctr == 16'd1);
  assign tx_tc      = (tx_ctr == 16'd1);
  assign rx_done    = (rx_st == S_STOP) && rx_tc;
  assign rx_good    = rx_done && rx_s2 && !rx_pbad;
  assign fifo_full  = (fifo_cnt == DEPTH);
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = (tx_st == S_IDLE) && tx_en && !fifo_empty;
  // a full FIFO still accepts the byte when the same cycle pops the head
  assign push       = rx_good && (!fifo_full || pop);
  assign head       = fifo_mem[rd_ptr] ^ xor_mask;

  assign busy  = (rx_st != S_IDLE) || (tx_st != S_IDLE);
  assign state = {rx_st != S_IDLE, tx_st != S_IDLE, fifo_full, fifo_empty,
                  1'b0, overrun, par_err, frm_err};

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= S_IDLE;
      rx_ctr  <= '0;
      rx_div  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_pen  <= 1'b0;
      rx_podd <= 1'b0;
      rx_pbad <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_st)
        S_IDLE: begin
          if (rx_en && rx_prev && !rx_s2) begin
            rx_st   <= S_START;
            rx_div  <= baud_div;
            rx_ctr  <= {1'b0, baud_div[15:1]};
            rx_pen  <= par_en;
            rx_podd <= par_odd;
            rx_pbad <= 1'b0;
            rx_bit  <= '0;
          end
        end
        default: begin
          if (!rx_tc) begin
            rx_ctr <= rx_ctr - 16'd1;
          end else begin
            rx_ctr <= rx_div;
            case (rx_st)
              S_START: rx_st <= rx_s2 ? S_IDLE : S_DATA;
              S_DATA: begin
                rx_sh  <= {rx_s2, rx_sh[7:1]};
                rx_bit <= rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_st <= rx_pen ? S_PARITY : S_STOP;
              end
              S_PARITY: begin
                rx_pbad <= (rx_s2 != (^rx_sh ^ rx_podd));
                rx_st   <= S_STOP;
              end
              default: rx_st <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_cnt   <= '0;
      err_cnt  <= '0;
      overrun  <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (rx_good) rx_cnt <= rx_cnt + 16'd1;
      if (rx_good && fifo_full && !pop) overrun <= 1'b1;
      if (rx_done && !rx_good) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        if (rx_pbad) par_err <= 1'b1;
        if (!rx_s2) frm_err <= 1'b1;
      end
      if (push) begin
        fifo_mem[wr_ptr] <= rx_sh;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_st   <= S_IDLE;
      tx      <= 1'b1;
      tx_ctr  <= '0;
      tx_div  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '0;
      tx_pen  <= 1'b0;
      tx_pbit <= 1'b0;
    end else begin
      case (tx_st)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            tx_sh   <= head;
            tx_pbit <= ^head ^ par_odd;
            tx_pen  <= par_en;
            tx_div  <= baud_div;
            tx_ctr  <= baud_div;
            tx      <= 1'b0;
            tx_st   <= S_START;
          end
        end
        default: begin
          if (!tx_tc) begin
            tx_ctr <= tx_ctr - 16'd1;
          end else begin
            tx_ctr <= tx_div;
            case (tx_st)
              S_START: begin
                tx     <= tx_sh[0];
                tx_bit <= '0;
                tx_st  <= S_DATA;
              end
              S_DATA: begin
                tx_sh  <= tx_sh >> 1;
                tx_bit <= tx_bit + 3'd1;
                if (tx_bit == 3'd7) begin
                  tx    <= tx_pen ? tx_pbit : 1'b1;
                  tx_st <= tx_pen ? S_PARITY : S_STOP;
                end else begin
                  tx <= tx_sh[1];
                end
              end
              S_PARITY: begin
                tx    <= 1'b1;
                tx_st <= S_STOP;
              end
              default: tx_st <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
